// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl: armed run-of-ones detector with a start / done / ack handshake
// and a saturating hit counter.
// Optional feature macro: SEQ_RUN_CTRL_TMO_EN adds the ARMED-cycle timer and
// the miss (timeout) result. Without it the tmo port is accepted but ignored,
// and ARMED is left only on a hit, an abort or a reset.
module seq_run_ctrl #(
  parameter int LEN_W = 4,
  parameter int TMO_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [TMO_W-1:0] tmo,
  input  logic             abort,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [LEN_W-1:0] run_cnt,
  output logic [CNT_W-1:0] hit_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic               busy_q;
  logic               done_q;
  logic               hit_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   run_cnt_q;
  logic [CNT_W-1:0]   hit_count_q;

  // Incremented run length; a hit is declared when it equals the target, so
  // the counter never has to count past len_q and cannot wrap.
  logic [LEN_W-1:0]   run_inc_d;
  // Hit counter plus one, pinned at all-ones once saturated.
  logic [CNT_W-1:0]   hit_count_d;

  assign run_inc_d   = run_cnt_q + 1'b1;
  assign hit_count_d = (&hit_count_q) ? hit_count_q : hit_count_q + 1'b1;

`ifdef SEQ_RUN_CTRL_TMO_EN
  logic [TMO_W-1:0]   tmo_q;
  logic [TMO_W-1:0]   timer_q;
  logic [TMO_W-1:0]   timer_d;
  logic               timeout_d;

  // Timer counts ARMED cycles; the timeout fires on the cycle the count
  // reaches the latched window (a zero window never fires).
  assign timer_d   = timer_q + 1'b1;
  assign timeout_d = (tmo_q != '0) && (timer_d == tmo_q);
`else
  // The tmo port has no function in this build.
  logic unused_tmo;
  assign unused_tmo = ^tmo;
`endif

  // Control FSM with all outputs held in registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      len_q       <= '0;
      run_cnt_q   <= '0;
      hit_count_q <= '0;
`ifdef SEQ_RUN_CTRL_TMO_EN
      tmo_q       <= '0;
      timer_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q     <= len;
            run_cnt_q <= '0;
            busy_q    <= 1'b1;
`ifdef SEQ_RUN_CTRL_TMO_EN
            tmo_q     <= tmo;
            timer_q   <= '0;
`endif
            if (len == '0) begin
              // Zero-length run is satisfied immediately.
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              hit_q       <= 1'b1;
              hit_count_q <= hit_count_d;
            end else begin
              state_q <= S_ARMED;
            end
          end
        end

        S_ARMED: begin
`ifdef SEQ_RUN_CTRL_TMO_EN
          timer_q <= timer_d;
`endif
          if (abort) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            run_cnt_q <= '0;
          end else if (x && (run_inc_d == len_q)) begin
            // Hit outranks a timeout landing on the same cycle.
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            hit_q       <= 1'b1;
            run_cnt_q   <= run_inc_d;
            hit_count_q <= hit_count_d;
          end else begin
            run_cnt_q <= x ? run_inc_d : '0;
`ifdef SEQ_RUN_CTRL_TMO_EN
            if (timeout_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hit_q   <= 1'b0;
            end
`endif
          end
        end

        S_DONE: begin
          // Result is held until acknowledged; start and abort are ignored.
          if (ack) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          hit_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hit       = hit_q;
  assign run_cnt   = run_cnt_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Testbench for seq_run_ctrl: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a behavioural model.
// Honours SEQ_RUN_CTRL_TMO_EN the same way as the design.
module tb_seq_run_ctrl;

  logic       clk;
  logic       rst;
  logic       x;
  logic       start;
  logic [3:0] len;
  logic [7:0] tmo;
  logic       abort;
  logic       ack;
  logic       busy;
  logic       done;
  logic       hit;
  logic [3:0] run_cnt;
  logic [7:0] hit_count;

  int compared   = 0;
  int mismatched = 0;

  // Model of the observable behaviour.
  bit m_busy, m_done, m_hit;
  int m_run, m_hcnt, m_len, m_tmo, m_elapsed;

  seq_run_ctrl #(.LEN_W(4), .TMO_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .x(x), .start(start), .len(len), .tmo(tmo),
    .abort(abort), .ack(ack), .busy(busy), .done(done), .hit(hit),
    .run_cnt(run_cnt), .hit_count(hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_step(input bit rx, input bit rstart, input int rlen,
                            input int rtmo, input bit rabort, input bit rack,
                            input bit rrst);
    if (rrst) begin
      m_busy = 0; m_done = 0; m_hit = 0; m_run = 0; m_hcnt = 0;
      m_len = 0; m_tmo = 0; m_elapsed = 0;
    end else if (!m_busy) begin
      if (rstart) begin
        m_len = rlen; m_tmo = rtmo; m_run = 0; m_elapsed = 0; m_busy = 1;
        if (rlen == 0) begin
          m_done = 1; m_hit = 1;
          if (m_hcnt < 255) m_hcnt++;
        end
      end
    end else if (!m_done) begin
      m_elapsed++;
      if (rabort) begin
        m_busy = 0; m_run = 0;
      end else if (rx && (m_run + 1 == m_len)) begin
        m_run = m_len; m_done = 1; m_hit = 1;
        if (m_hcnt < 255) m_hcnt++;
      end else begin
        m_run = rx ? m_run + 1 : 0;
`ifdef SEQ_RUN_CTRL_TMO_EN
        if (m_tmo != 0 && m_elapsed == m_tmo) begin
          m_done = 1; m_hit = 0;
        end
`endif
      end
    end else if (rack) begin
      m_busy = 0; m_done = 0; m_hit = 0;
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic cyc(input bit rx, input bit rstart, input int rlen,
                     input int rtmo, input bit rabort, input bit rack,
                     input bit rrst);
    x = rx; start = rstart; len = 4'(rlen); tmo = 8'(rtmo);
    abort = rabort; ack = rack; rst = rrst;
    @(posedge clk);
    #1;
    model_step(rx, rstart, rlen, rtmo, rabort, rack, rrst);
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    chk("hit", int'(hit), int'(m_hit));
    chk("run_cnt", int'(run_cnt), m_run);
    chk("hit_count", int'(hit_count), m_hcnt);
  endtask

  task automatic idle_cyc(input bit rx);
    cyc(rx, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int exp_run[6];
    bit bx[6];
    x = 0; start = 0; len = 0; tmo = 0; abort = 0; ack = 0; rst = 1;
    #2;

    // Reset state.
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hit_count", int'(hit_count), 0);
    idle_cyc(0);

    // len=3, three ones -> hit.
    cyc(0, 1, 3, 0, 0, 0, 0);
    idle_cyc(1); idle_cyc(1);
    chk("s1_no_early_done", int'(done), 0);
    idle_cyc(1);
    chk("s1_done", int'(done), 1);
    chk("s1_hit", int'(hit), 1);
    chk("s1_hit_count", int'(hit_count), 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("s1_ack_busy", int'(busy), 0);

    // len=3 with a broken run: 1,1,0,1,1,1.
    bx = '{1, 1, 0, 1, 1, 1};
    exp_run = '{1, 2, 0, 1, 2, 3};
    cyc(0, 1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      idle_cyc(bx[i]);
      chk("s2_run_cnt", int'(run_cnt), exp_run[i]);
      chk("s2_done", int'(done), (i == 5) ? 1 : 0);
    end
    chk("s2_hit_count", int'(hit_count), 2);
    cyc(0, 0, 0, 0, 0, 1, 0);

`ifdef SEQ_RUN_CTRL_TMO_EN
    // Timeout: len=4 tmo=5, x=1,1,0,1,1 -> miss after fifth sample.
    bx = '{1, 1, 0, 1, 1, 0};
    cyc(0, 1, 4, 5, 0, 0, 0);
    for (int i = 0; i < 5; i++) idle_cyc(bx[i]);
    chk("tmo_done", int'(done), 1);
    chk("tmo_hit", int'(hit), 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    // Tie: len=4 tmo=4, four ones -> hit wins.
    cyc(0, 1, 4, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle_cyc(1);
    chk("tie_done", int'(done), 1);
    chk("tie_hit", int'(hit), 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
`else
    // Timeout disabled: tmo=1 ignored, run never completes.
    cyc(0, 1, 2, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) idle_cyc(0);
    chk("notmo_done", int'(done), 0);
    chk("notmo_busy", int'(busy), 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
`endif

    // Abort at the second ARMED cycle.
    cyc(0, 1, 3, 0, 0, 0, 0);
    idle_cyc(1);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_run_cnt", int'(run_cnt), 0);

    // start together with ack in DONE is ignored.
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("len0_done", int'(done), 1);
    cyc(0, 1, 2, 0, 0, 1, 0);
    chk("startack_busy", int'(busy), 0);
    idle_cyc(0);
    chk("startack_stays_idle", int'(busy), 0);

    // Reset mid-run with run_cnt=2.
    cyc(0, 1, 4, 0, 0, 0, 0);
    idle_cyc(1); idle_cyc(1);
    chk("mid_run_cnt", int'(run_cnt), 2);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_run_cnt", int'(run_cnt), 0);
    chk("mid_rst_hit_count", int'(hit_count), 0);

    // 256 zero-length runs saturate the hit counter.
    for (int i = 0; i < 256; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
    end
    chk("sat_hit_count", int'(hit_count), 255);

    // Randomized traffic.
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 7),
          ($urandom_range(0, 2) == 0),
          int'($urandom_range(0, 5)),
          int'($urandom_range(0, 9)),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 4) < 2),
          ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
